// File: rtl/serial_mac_engine.sv
// Serial-mode MAC responder: fetches 4 weights and a 2x2 feature window from a
// shared synchronous memory and returns their dot product with a one-cycle done
// pulse. Build option SERIAL_MAC_SIGNED_EN selects signed arithmetic.
module serial_mac_engine #(
  parameter logic [5:0] WEIGHT_BASE = 6'd0,
  parameter int         ROW_W       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_mode_en,
  input  logic [7:0]  serial_mode_feature_baseaddr,
  output logic [5:0]  mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_data,
  output logic [17:0] result,
  output logic        serial_mode_done,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  // Handshake: serial_mode_en is a level request sampled every rising edge;
  // serial_mode_done is a single-cycle pulse with result valid from that cycle on.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] OFF_ROW  = 6'(ROW_W);
  localparam logic [5:0] OFF_ROW1 = 6'(ROW_W + 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  base_q, base_d;
  logic [17:0] acc_q, acc_d;
  logic [7:0]  weight_q, weight_d;
  logic [17:0] result_q, result_d;
  logic [5:0]  addr_q, addr_d;

  logic [5:0]  feat_off;
  logic [5:0]  fetch_addr;
  logic [15:0] w_ext;
  logic [15:0] d_ext;
  logic [15:0] prod;
  logic [17:0] prod_ext;
  logic        unused_base_hi;

  assign unused_base_hi = ^serial_mode_feature_baseaddr[7:6];

  always_comb begin
    feat_off = 6'd0;
    case (cnt_q[2:1])
      2'd0:    feat_off = 6'd0;
      2'd1:    feat_off = 6'd1;
      2'd2:    feat_off = OFF_ROW;
      default: feat_off = OFF_ROW1;
    endcase
  end

  // Even slots fetch weight i, odd slots fetch feature i; 6-bit sums wrap mod 64.
  assign fetch_addr = cnt_q[0] ? (base_q + feat_off)
                               : (WEIGHT_BASE + {4'd0, cnt_q[2:1]});

`ifdef SERIAL_MAC_SIGNED_EN
  assign w_ext    = {{8{weight_q[7]}}, weight_q};
  assign d_ext    = {{8{mem_data[7]}}, mem_data};
  assign prod     = w_ext * d_ext;
  assign prod_ext = {{2{prod[15]}}, prod};
`else
  assign w_ext    = {8'd0, weight_q};
  assign d_ext    = {8'd0, mem_data};
  assign prod     = w_ext * d_ext;
  assign prod_ext = {2'd0, prod};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    acc_d    = acc_q;
    weight_d = weight_q;
    result_d = result_q;
    addr_d   = addr_q;
    case (state_q)
      S_IDLE: begin
        if (serial_mode_en) begin
          base_d  = serial_mode_feature_baseaddr[5:0];
          acc_d   = 18'd0;
          cnt_d   = 3'd0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        addr_d = fetch_addr;
        if (!serial_mode_en) begin
          state_d = S_IDLE;
        end else begin
          // Data arriving now belongs to slot cnt-1: odd cnt => weight, even => feature.
          if (cnt_q[0]) begin
            weight_d = mem_data;
          end else if (cnt_q != 3'd0) begin
            acc_d = acc_q + prod_ext;
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!serial_mode_en) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_q + prod_ext;
          result_d = acc_q + prod_ext;
          state_d  = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      base_q   <= 6'd0;
      acc_q    <= 18'd0;
      weight_q <= 8'd0;
      result_q <= 18'd0;
      addr_q   <= 6'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      acc_q    <= acc_d;
      weight_q <= weight_d;
      result_q <= result_d;
      addr_q   <= addr_d;
    end
  end

  // Outside FETCH the address bus keeps the last fetched address.
  assign mem_addr         = (state_q == S_FETCH) ? fetch_addr : addr_q;
  assign mem_rd_en        = (state_q == S_FETCH);
  assign serial_mode_done = (state_q == S_DONE);
  assign busy             = (state_q != S_IDLE);
  assign result           = result_q;
  assign dbg_state_o      = state_q;

endmodule

// File: doc/serial_mac_engine.md
Name: serial_mac_engine

Overview:
Responder for the controller's serial-mode handshake. While serial_mode_en is high it fetches four weights and one 2x2 feature window from the shared 64x8 data memory, starting at the controller-supplied feature base address. It accumulates the 4-term dot product and returns the result with a one-cycle serial_mode_done pulse. The engine re-arms automatically so the controller can run consecutive strides without dropping enable.

Parameters:
WEIGHT_BASE, 0, 6-bit memory address of weight w0; weights wi sit at WEIGHT_BASE+i, i=0..3.
ROW_W, 3, feature-map row width in words; the window is base+{0, 1, ROW_W, ROW_W+1}.

Ports:
clk  input  1  system clock, all state changes on the rising edge.
rst  input  1  asynchronous active-low reset.
serial_mode_en  input  1  level request from the controller.
serial_mode_feature_baseaddr  input  8  feature window base address; only bits [5:0] are used.
mem_addr  output  6  memory read address.
mem_rd_en  output  1  read strobe, high only in FETCH.
mem_data  input  8  synchronous memory read data, valid 1 cycle after its address.
result  output  18  last completed dot product.
serial_mode_done  output  1  one-cycle completion pulse.
busy  output  1  high in FETCH, DRAIN and DONE.

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs: mem_addr=0, mem_rd_en=0, result=0, serial_mode_done=0, busy=0. State goes to IDLE; counter, accumulator and weight register clear.
- States and transitions:
  - IDLE: when serial_mode_en=1 at a rising edge, latch base[5:0], clear the accumulator, set cnt=0, go to FETCH.
  - FETCH: runs 8 cycles, cnt 0..7. mem_rd_en=1. Fetch order: W0, F0, W1, F1, W2, F2, W3, F3.
  - Even cnt=2i drives mem_addr=WEIGHT_BASE+i.
  - Odd cnt drives the feature address base+off_i, with off = {0, 1, ROW_W, ROW_W+1}.
  - DRAIN: 1 cycle; the last feature's data is consumed.
  - DONE: 1 cycle; serial_mode_done=1 and result is updated. Next state is IDLE unconditionally.
- Datapath: mem_data sampled on the edge ending cycle cnt+1.
  - Even-index data is loaded into the weight register.
  - Odd-index data is multiplied by the weight register (8x8 -> 16 bit) and added to the 18-bit accumulator.
- Unsigned maximum is 4*255*255 = 260100, so the accumulator never overflows.
- Latency: after the start-sampling edge E0, serial_mode_done is high during the cycle following edge E9. One operation occupies exactly 10 cycles.
- result is written only in DONE and holds its value until the next DONE or reset.
- Re-arm: IDLE is always occupied for at least 1 cycle after DONE. If en is still high, the next operation starts at the edge ending that IDLE cycle and samples the base value present then. This lets the controller update the base on the done edge.
- Address arithmetic is modulo 64. Example: base 63, ROW_W 3 reads 63, 0, 2, 3. Bits [7:6] of the base are ignored.
- If en goes low during FETCH or DRAIN, the operation aborts: return to IDLE next edge, no done pulse, result unchanged.
- en low in the DONE cycle has no effect; the pulse still occurs.
- mem_addr holds its last value whenever mem_rd_en=0.

Optional Feature:
SERIAL_MAC_SIGNED_EN
- Defined: mem_data for weights and features is signed two's complement, products are signed 16-bit, and result is signed 18-bit. Range -65024..65536 fits.
- Undefined: everything is unsigned. Timing is identical in both builds.

Test Plan:
- Setup for the stride tests: mem[0..3]=1,2,3,4; mem[16..24]=1..9; defaults.
- Stride walk: en=1, base=16 -> done pulse 10 cycles after start, result=37.
  - Keep en high and change base to 17, then 19, then 20 on each done edge -> results 47, 67, 77.
- Exactly one IDLE cycle precedes each re-start.
- Max/format: all weights=0xFF and window=0x80.
  - Unsigned build -> result=130560.
  - SERIAL_MAC_SIGNED_EN build -> result=512; with weights 0x7F -> result=-65024.
- Full scale: all memory=0xFF, unsigned -> result=260100, no wrap.
- Wrap: base=63, ROW_W=3 -> mem_addr sequence 0, 63, 1, 0, 2, 2, 3, 3.
- Abort/reset:
  - Drop en at cnt=4 -> no done and result keeps its previous value (77).
  - Assert rst=0 mid-FETCH -> all outputs 0 immediately; after rst=1 with en=1, a clean 10-cycle operation follows.
